// File: rtl/audio_pkg.sv
// Shared audio-path definitions: default sample width and the state encodings
// used by the stereo sample buffer.
package audio_pkg;

  localparam int DEFAULT_DATA_W = 24;

  typedef enum logic [1:0] {P_IDLE, P_HAVE_L, P_HAVE_R} pair_state_t;
  typedef enum logic [1:0] {STOPPED, PRIME, STREAM} stream_state_t;

endpackage

// File: rtl/stereo_fifo_mem.sv
// Simple dual-port frame RAM: synchronous write, registered read.
// A read of the slot being written returns the old contents.
module stereo_fifo_mem #(
  parameter int WIDTH  = 48,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/stereo_sample_fifo.sv
// Elastic stereo buffer: pairs L/R strobes into frames, primes to half-full,
// then hands one frame per serializer request; mutes and re-primes on underrun.
module stereo_sample_fifo
  import audio_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  l_data_en,
  input  logic                  r_data_en,
  input  logic [DATA_W-1:0]     l_data_in,
  input  logic [DATA_W-1:0]     r_data_in,
  input  logic                  rd_req,
  input  logic                  clr_flags,
  output logic                  dout_valid,
  output logic [DATA_W-1:0]     l_data_out,
  output logic [DATA_W-1:0]     r_data_out,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  streaming,
  output logic                  underrun,
  output logic                  overrun,
  output logic                  pair_err
);

  localparam int FRAME_W = 2 * DATA_W;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] HALF_LEVEL = (DEPTH_LOG2+1)'(2**(DEPTH_LOG2-1));

  pair_state_t   pair_state_reg, pair_state_next;
  stream_state_t stream_state_reg, stream_state_next;
  logic [DATA_W-1:0]     hold_reg, hold_next;
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [DEPTH_LOG2:0]   level_reg;
  logic                  dout_valid_reg, out_zero_reg;
  logic                  underrun_reg, overrun_reg, pair_err_reg;
  logic [FRAME_W-1:0]    pair_frame, rd_frame;
  logic                  pair_wr, pair_dup;
  logic                  full, empty, rd_accept, wr_accept;
  logic                  underrun_evt, overrun_evt, pair_err_evt;

  assign full         = (level_reg == FULL_LEVEL);
  assign empty        = (level_reg == '0);
  assign rd_accept    = run && rd_req && (stream_state_reg == STREAM) && !empty;
  assign underrun_evt = run && rd_req && (stream_state_reg == STREAM) && empty;
  // A full FIFO still takes a frame when a read frees a slot in the same cycle.
  assign wr_accept    = run && pair_wr && (!full || rd_accept);
  assign overrun_evt  = run && pair_wr && full && !rd_accept;
  assign pair_err_evt = run && pair_dup;

  // Pair FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pair_state_reg <= P_IDLE;
      hold_reg       <= '0;
    end else if (!run) begin
      pair_state_reg <= P_IDLE;
      hold_reg       <= '0;
    end else begin
      pair_state_reg <= pair_state_next;
      hold_reg       <= hold_next;
    end
  end

  always_comb begin
    pair_state_next = pair_state_reg;
    hold_next       = hold_reg;
    case (pair_state_reg)
      P_IDLE: begin
        if (l_data_en && !r_data_en) begin
          hold_next       = l_data_in;
          pair_state_next = P_HAVE_L;
        end else if (r_data_en && !l_data_en) begin
          hold_next       = r_data_in;
          pair_state_next = P_HAVE_R;
        end
      end
      P_HAVE_L: begin
        if (l_data_en)      hold_next       = l_data_in;
        else if (r_data_en) pair_state_next = P_IDLE;
      end
      P_HAVE_R: begin
        if (r_data_en)      hold_next       = r_data_in;
        else if (l_data_en) pair_state_next = P_IDLE;
      end
      default: pair_state_next = P_IDLE;
    endcase
  end

  always_comb begin
    pair_wr    = 1'b0;
    pair_dup   = 1'b0;
    pair_frame = '0;
    case (pair_state_reg)
      P_IDLE: begin
        pair_wr    = l_data_en && r_data_en;
        pair_frame = {l_data_in, r_data_in};
      end
      P_HAVE_L: begin
        pair_wr    = r_data_en;
        pair_dup   = l_data_en && !r_data_en;
        pair_frame = {hold_reg, r_data_in};
      end
      P_HAVE_R: begin
        pair_wr    = l_data_en;
        pair_dup   = r_data_en && !l_data_en;
        pair_frame = {l_data_in, hold_reg};
      end
      default: ;
    endcase
  end

  // Stream FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stream_state_reg <= STOPPED;
    else       stream_state_reg <= stream_state_next;
  end

  always_comb begin
    stream_state_next = stream_state_reg;
    if (!run) begin
      stream_state_next = STOPPED;
    end else begin
      case (stream_state_reg)
        STOPPED: stream_state_next = PRIME;
        PRIME:   if (level_reg >= HALF_LEVEL) stream_state_next = STREAM;
        STREAM:  if (underrun_evt) stream_state_next = PRIME;
        default: stream_state_next = STOPPED;
      endcase
    end
  end

  always_comb begin
    streaming = (stream_state_reg == STREAM);
  end

  // Pointers, level and read-response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      dout_valid_reg <= 1'b0;
      out_zero_reg   <= 1'b1;
    end else if (!run) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      dout_valid_reg <= 1'b0;
      out_zero_reg   <= 1'b1;
    end else begin
      if (wr_accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_accept) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_accept, rd_accept})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: ;
      endcase
      dout_valid_reg <= rd_req;
      // Refused requests mute the outputs; the RAM read register keeps the last frame.
      if (rd_req) out_zero_reg <= !rd_accept;
    end
  end

  // Sticky flags: a new event beats a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun_reg <= 1'b0;
      overrun_reg  <= 1'b0;
      pair_err_reg <= 1'b0;
    end else begin
      if (underrun_evt)   underrun_reg <= 1'b1;
      else if (clr_flags) underrun_reg <= 1'b0;
      if (overrun_evt)    overrun_reg  <= 1'b1;
      else if (clr_flags) overrun_reg  <= 1'b0;
      if (pair_err_evt)   pair_err_reg <= 1'b1;
      else if (clr_flags) pair_err_reg <= 1'b0;
    end
  end

  stereo_fifo_mem #(
    .WIDTH  (FRAME_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_reg),
    .wr_data (pair_frame),
    .rd_en   (rd_accept),
    .rd_addr (rd_ptr_reg),
    .rd_data (rd_frame)
  );

  assign dout_valid = dout_valid_reg;
  assign l_data_out = out_zero_reg ? '0 : rd_frame[FRAME_W-1:DATA_W];
  assign r_data_out = out_zero_reg ? '0 : rd_frame[DATA_W-1:0];
  assign level      = level_reg;
  assign underrun   = underrun_reg;
  assign overrun    = overrun_reg;
  assign pair_err   = pair_err_reg;

endmodule
